fetch_unit: RTL and testbench

Instruction fetch stage for the RV32 core. It sits directly upstream of the IF/DR pipeline register and drives the synchronous instruction memory. It holds the fetch PC, issues one read per cycle and buffers returned instructions with their PCs in a small prefetch queue. It presents them to decode over a valid/ready handshake and restarts fetch on a branch/jump redirect from execute.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
// Optional feature macro used by fetch_unit: FETCH_BYPASS_EN.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1'b1);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;

  // Entry storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_r[wr_ptr_r] <= push_entry;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Read/write pointers (natural power-of-two wrap) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-read-per-cycle issue, prefetch queue and redirect.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]  fetch_pc_r;
  logic [31:0]  inflight_pc_r;
  logic         inflight_r;

  logic [CW-1:0] q_count_s;
  fetch_entry_t  q_head_s;
  fetch_entry_t  push_entry_s;
  logic          resp_s;
  logic          bypass_s;
  logic          pop_s;
  logic          q_push_s;
  logic          q_pop_s;
  logic          issue_s;
  logic [CW:0]   occupancy_s;
  logic [CW:0]   limit_s;

  // Handshake, queue control and issue decision for the current cycle.
  always_comb begin
    resp_s       = inflight_r & ~redirect_valid;
    push_entry_s = '{pc: inflight_pc_r, instr: imem_rdata};
`ifdef FETCH_BYPASS_EN
    bypass_s     = resp_s & (q_count_s == '0);
`else
    bypass_s     = 1'b0;
`endif
    if (bypass_s) begin
      if_valid       = 1'b1;
      if_pc          = inflight_pc_r;
      if_instruction = imem_rdata;
    end else begin
      if_valid       = (q_count_s != '0) & ~redirect_valid;
      if_pc          = q_head_s.pc;
      if_instruction = q_head_s.instr;
    end
    pop_s    = if_valid & if_ready;
    q_pop_s  = pop_s & ~bypass_s;
    q_push_s = resp_s & ~(bypass_s & pop_s);
    // Issue only if the response is guaranteed a slot once this cycle's pop retires.
    occupancy_s = {1'b0, q_count_s} + {{CW{1'b0}}, inflight_r};
    limit_s     = (CW + 1)'(QUEUE_DEPTH) + {{CW{1'b0}}, pop_s};
    issue_s     = rst_n & ~redirect_valid & (occupancy_s < limit_s);
  end

  // Fetch PC and in-flight read tracking; redirect overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
    end else if (redirect_valid) begin
      fetch_pc_r    <= align_pc(redirect_pc);
      inflight_r    <= 1'b0;
      inflight_pc_r <= inflight_pc_r;
    end else if (issue_s) begin
      fetch_pc_r    <= fetch_pc_r + 32'd4;
      inflight_r    <= 1'b1;
      inflight_pc_r <= fetch_pc_r;
    end else begin
      fetch_pc_r    <= fetch_pc_r;
      inflight_r    <= 1'b0;
      inflight_pc_r <= inflight_pc_r;
    end
  end

  assign imem_en   = issue_s;
  assign imem_addr = fetch_pc_r;

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push_s),
    .push_entry(push_entry_s),
    .pop       (q_pop_s),
    .flush     (redirect_valid),
    .count     (q_count_s),
    .head      (q_head_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus a random ready/redirect phase.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;

  int          n_checks = 0;
  int          n_fail = 0;
  int          accepted = 0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] model_tail = 32'h0;
  logic [31:0] wrap_tbl [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (RST_PC),
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instruction(if_instruction),
    .if_pc         (if_pc)
  );

  // Synchronous instruction memory whose contents equal the address.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(model_tail);
      model_tail = model_tail + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] pc);
    exp_q.delete();
    model_tail = pc;
    refill();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  // Monitor: every accepted instruction must be the next one the reference stream predicts.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      n_checks++;
      if (dut.q_count_s > 2'(DEPTH)) begin
        n_fail++;
        $display("FAIL queue_bound: got %0d expected <= %0d", dut.q_count_s, DEPTH);
      end
      if (if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: got pc %h expected no acceptance", if_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("sb_pc", if_pc, e);
          check("sb_instr", if_instruction, e);
          accepted++;
        end
      end
    end
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", 32'(imem_en), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instruction, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_addr", imem_addr, RST_PC);

    // Streaming from reset with decode always ready
    if_ready = 1'b1;
    restart(RST_PC);
    mon_en = 1'b1;
    rst_n = 1'b1;
    #3;
    check("a_addr0", imem_addr, RST_PC);
    check("a_en0", 32'(imem_en), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      #3;
      check("a_addr", imem_addr, RST_PC + 32'(4 * k));
      check("a_en", 32'(imem_en), 32'd1);
      check("a_valid", 32'(if_valid), 32'(k >= LAT));
    end

    // Reset pulsed mid-stream: outputs clear at once
    tick();
    rst_n = 1'b0;
    #1;
    check("r_valid", 32'(if_valid), 32'd0);
    check("r_en", 32'(imem_en), 32'd0);
    check("r_instr", if_instruction, 32'h0);
    check("r_addr", imem_addr, RST_PC);
    tick();
    if_ready = 1'b0;
    restart(RST_PC);
    rst_n = 1'b1;
    #3;
    check("s_addr0", imem_addr, RST_PC);
    // Decode stalls for 5 cycles after the first valid
    for (int k = 1; k <= 6; k++) begin
      tick();
      #3;
      check("s_valid", 32'(if_valid), 32'(k >= LAT));
      if (k >= LAT) check("s_pc_hold", if_pc, exp_q[0]);
    end
    check("s_en_low", 32'(imem_en), 32'd0);
    check("s_addr_hold", imem_addr, RST_PC + 32'd8);
    check("s_count", 32'(dut.q_count_s), 32'(DEPTH));
    check("s_head", if_pc, RST_PC);
    tick();
    if_ready = 1'b1;
    repeat (4) tick();

    // Redirect with entries buffered and a read in flight
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0103;
    restart(32'h8000_0100);
    #3;
    check("c_valid_n", 32'(if_valid), 32'd0);
    check("c_en_n", 32'(imem_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    #3;
    check("c_addr_n1", imem_addr, 32'h8000_0100);
    check("c_en_n1", 32'(imem_en), 32'd1);
    tick();
    #3;
    check("c_valid_n2", 32'(if_valid), 32'(LAT == 1));
    tick();
    #3;
    check("c_valid_n3", 32'(if_valid), 32'd1);
    check("c_pc_n3", if_pc, 32'h8000_0100);
    tick();
    if_ready = 1'b1;
    repeat (3) tick();

    // Redirect near the top of the address space: fetch wraps to zero
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    restart(32'hFFFF_FFF8);
    for (int k = 0; k < 4; k++) begin
      tick();
      redirect_valid = 1'b0;
      #3;
      check("w_addr", imem_addr, wrap_tbl[k]);
      check("w_en", 32'(imem_en), 32'd1);
    end
    repeat (4) tick();

    // Random ready toggling with random redirects
    for (int c = 0; c < 1000; c++) begin
      tick();
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_pc = $urandom;
        redirect_valid = 1'b1;
        restart({redirect_pc[31:2], 2'b00});
      end else begin
        redirect_valid = 1'b0;
      end
    end
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    repeat (6) tick();
    check("progress", 32'(accepted > 200), 32'd1);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
